// File: rtl/grf_write_arbiter_if.sv
// Bundle for the GRF write arbiter: WB port (A), mul/div result port (B),
// hazard queries and the retiring GRF write.
// B handshake: a request transfers on a Clk edge where md_valid && md_ready;
// md_ready never depends on md_valid, and B holds md_wa/md_wd/md_pc stable while md_valid waits.
interface grf_write_arbiter_if;
  logic        wb_we;
  logic [4:0]  wb_wa;
  logic [31:0] wb_wd;
  logic [31:0] wb_pc;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_wa;
  logic [31:0] md_wd;
  logic [31:0] md_pc;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic        hit1;
  logic        hit2;
  logic        starve_req;
  logic        grf_we;
  logic [4:0]  grf_wa;
  logic [31:0] grf_wd;
  logic [31:0] grf_pc;

  modport master (
    output wb_we, wb_wa, wb_wd, wb_pc,
    output md_valid, md_wa, md_wd, md_pc,
    output ra1, ra2,
    input  md_ready, hit1, hit2, starve_req,
    input  grf_we, grf_wa, grf_wd, grf_pc
  );

  modport slave (
    input  wb_we, wb_wa, wb_wd, wb_pc,
    input  md_valid, md_wa, md_wd, md_pc,
    input  ra1, ra2,
    output md_ready, hit1, hit2, starve_req,
    output grf_we, grf_wa, grf_wd, grf_pc
  );
endinterface

// File: rtl/grf_write_arbiter.sv
// Shares the GRF write port between WB (A, priority) and a FIFO-buffered mul/div path (B).
// Optional write trace enabled by defining GRF_WRITE_TRACE_EN.
module grf_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic                 Clk,
  input logic                 reset,
  grf_write_arbiter_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  logic [4:0]       fifo_wa [DEPTH];
  logic [31:0]      fifo_wd [DEPTH];
  logic [31:0]      fifo_pc [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [SC_W-1:0]  starve_cnt;
  logic             starve_q;

  logic             out_we;
  logic [4:0]       out_wa;
  logic [31:0]      out_wd;
  logic [31:0]      out_pc;

  logic             full;
  logic             empty;
  logic             ready;
  logic             push;
  logic             pop;
  logic             grant_a;
  logic             load_we;
  logic [4:0]       load_wa;
  logic [31:0]      load_wd;
  logic [31:0]      load_pc;
  logic             match1;
  logic             match2;
  logic [PTR_W-1:0] off;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  // Gated by reset so the reset cycle never accepts into a FIFO being cleared.
  assign ready   = !reset && !full;
  assign push    = bus.md_valid && ready;
  assign grant_a = bus.wb_we;
  assign pop     = !grant_a && !empty;

  // Writes to $0 are consumed by the grant but never reach the register file.
  always_comb begin
    load_we = 1'b0;
    load_wa = bus.wb_wa;
    load_wd = bus.wb_wd;
    load_pc = bus.wb_pc;
    if (grant_a) begin
      load_we = (bus.wb_wa != 5'd0);
    end else if (pop) begin
      load_wa = fifo_wa[rd_ptr];
      load_wd = fifo_wd[rd_ptr];
      load_pc = fifo_pc[rd_ptr];
      load_we = (fifo_wa[rd_ptr] != 5'd0);
    end
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      fifo_wa[wr_ptr] <= bus.md_wa;
      fifo_wd[wr_ptr] <= bus.md_wd;
      fifo_pc[wr_ptr] <= bus.md_pc;
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      out_we <= 1'b0;
      out_wa <= '0;
      out_wd <= '0;
      out_pc <= '0;
    end else begin
      out_we <= load_we;
      if (load_we) begin
        out_wa <= load_wa;
        out_wd <= load_wd;
        out_pc <= load_pc;
      end
    end
  end

  // Counts cycles A wins while B waits; the request drops only when B actually wins.
  always_ff @(posedge Clk) begin
    if (reset) begin
      starve_cnt <= '0;
      starve_q   <= 1'b0;
    end else begin
      if (empty || pop)
        starve_cnt <= '0;
      else if (grant_a && starve_cnt != SC_W'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + SC_W'(1);
      if (pop)
        starve_q <= 1'b0;
      else if (starve_cnt == SC_W'(STARVE_LIMIT))
        starve_q <= 1'b1;
    end
  end

  // An entry is live when its distance from the head is below the occupancy.
  always_comb begin
    match1 = out_we && (out_wa == bus.ra1);
    match2 = out_we && (out_wa == bus.ra2);
    off    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PTR_W'(i) - rd_ptr;
      if ({1'b0, off} < count) begin
        if (fifo_wa[i] == bus.ra1) match1 = 1'b1;
        if (fifo_wa[i] == bus.ra2) match2 = 1'b1;
      end
    end
  end

  assign bus.hit1       = (bus.ra1 != 5'd0) && match1;
  assign bus.hit2       = (bus.ra2 != 5'd0) && match2;
  assign bus.md_ready   = ready;
  assign bus.starve_req = starve_q;
  assign bus.grf_we     = out_we;
  assign bus.grf_wa     = out_wa;
  assign bus.grf_wd     = out_wd;
  assign bus.grf_pc     = out_pc;

`ifdef GRF_WRITE_TRACE_EN
  always_ff @(posedge Clk) begin
    if (!reset && load_we)
      $display("%d@%h: $%d <= %h", $time, load_pc, load_wa, load_wd);
  end
`endif

endmodule

// File: tb/tb_grf_write_arbiter.sv
// Bench for grf_write_arbiter: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_grf_write_arbiter;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  grf_write_arbiter_if bus();

  grf_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .Clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // exp_q entries are {wa, wd, pc}; head is the oldest buffered B write.
  logic [68:0] exp_q[$];
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  logic [31:0] m_pc;
  int          m_scnt;
  logic        m_sreq;
  bit          model_ok = 0;
  int          m_sz;
  bit          m_ga;
  bit          m_gb;
  logic [68:0] m_head;

  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
      m_we = 0; m_wa = '0; m_wd = '0; m_pc = '0;
      m_scnt = 0; m_sreq = 0;
      model_ok = 1;
    end else if (model_ok) begin
      m_sz = exp_q.size();
      m_ga = bus.wb_we;
      m_gb = !m_ga && (m_sz > 0);
      if (m_gb) m_sreq = 0;
      else if (m_scnt == LIMIT) m_sreq = 1;
      if (m_sz == 0 || m_gb) m_scnt = 0;
      else if (m_ga && m_scnt < LIMIT) m_scnt = m_scnt + 1;
      m_we = 0;
      if (m_ga) begin
        if (bus.wb_wa != 0) begin
          m_we = 1; m_wa = bus.wb_wa; m_wd = bus.wb_wd; m_pc = bus.wb_pc;
        end
      end else if (m_gb) begin
        m_head = exp_q.pop_front();
        if (m_head[68:64] != 0) begin
          m_we = 1; m_wa = m_head[68:64]; m_wd = m_head[63:32]; m_pc = m_head[31:0];
        end
      end
      if (bus.md_valid && m_sz < DEPTH)
        exp_q.push_back({bus.md_wa, bus.md_wd, bus.md_pc});
    end
  end

  function automatic bit pending(input logic [4:0] ra);
    if (ra == 0) return 0;
    if (m_we && m_wa == ra) return 1;
    foreach (exp_q[i]) if (exp_q[i][68:64] == ra) return 1;
    return 0;
  endfunction

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (model_ok) begin
      check("grf_we", bus.grf_we, m_we);
      check("grf_wa", bus.grf_wa, m_wa);
      check("grf_wd", bus.grf_wd, m_wd);
      check("grf_pc", bus.grf_pc, m_pc);
      check("starve_req", bus.starve_req, m_sreq);
      check("md_ready", bus.md_ready, (!reset && exp_q.size() < DEPTH));
      check("hit1", bus.hit1, pending(bus.ra1));
      check("hit2", bus.hit2, pending(bus.ra2));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wb_we = 0; bus.wb_wa = '0; bus.wb_wd = '0; bus.wb_pc = '0;
    bus.md_valid = 0; bus.md_wa = '0; bus.md_wd = '0; bus.md_pc = '0;
  endtask

  task automatic drive_a(input logic [4:0] wa, input logic [31:0] wd, input logic [31:0] pc);
    bus.wb_we = 1; bus.wb_wa = wa; bus.wb_wd = wd; bus.wb_pc = pc;
  endtask

  task automatic drive_b(input logic [4:0] wa, input logic [31:0] wd, input logic [31:0] pc);
    bus.md_valid = 1; bus.md_wa = wa; bus.md_wd = wd; bus.md_pc = pc;
  endtask

  // ---------------- stimulus ----------------
  int pct;

  initial begin
    idle_inputs();
    bus.ra1 = '0; bus.ra2 = '0;
    reset = 1;
    step(); step();
    check("rst_grf_we", bus.grf_we, 0);
    check("rst_grf_wa", bus.grf_wa, 0);
    check("rst_starve", bus.starve_req, 0);
    check("rst_md_ready_low", bus.md_ready, 0);
    reset = 0;
    #1;
    check("rst_md_ready_high", bus.md_ready, 1);

    // A write, one-cycle latency
    drive_a(5'd5, 32'h1234, 32'h3000);
    step();
    idle_inputs();
    check("s1_we", bus.grf_we, 1);
    check("s1_wa", bus.grf_wa, 5);
    check("s1_wd", bus.grf_wd, 32'h1234);
    check("s1_pc", bus.grf_pc, 32'h3000);
    step();
    check("s1_we_off", bus.grf_we, 0);
    check("s1_hold_wa", bus.grf_wa, 5);

    // B write, two-cycle latency, hit tracking
    bus.ra1 = 5'd8;
    drive_b(5'd8, 32'hABCD, 32'h4000);
    step();
    idle_inputs();
    check("s2_hit_fifo", bus.hit1, 1);
    check("s2_we_pending", bus.grf_we, 0);
    step();
    check("s2_we", bus.grf_we, 1);
    check("s2_wa", bus.grf_wa, 8);
    check("s2_wd", bus.grf_wd, 32'hABCD);
    check("s2_hit_out", bus.hit1, 1);
    step();
    check("s2_we_off", bus.grf_we, 0);
    check("s2_hit_clear", bus.hit1, 0);

    // A hogs the port: fill FIFO, starvation, in-order drain
    drive_a(5'd20, 32'h5555, 32'h5000);
    for (int k = 0; k < 4; k++) begin
      drive_b(5'(10 + k), 32'(k), 32'h6000 + 32'(k));
      step();
    end
    bus.md_valid = 0;
    check("s3_full", bus.md_ready, 0);
    for (int k = 0; k < 5; k++) step();
    check("s3_no_starve_yet", bus.starve_req, 0);
    step();
    check("s3_starve", bus.starve_req, 1);
    idle_inputs();
    step();
    check("s3_first_b_wa", bus.grf_wa, 10);
    check("s3_starve_clear", bus.starve_req, 0);
    for (int k = 1; k < 4; k++) begin
      step();
      check("s3_order_we", bus.grf_we, 1);
      check("s3_order_wa", bus.grf_wa, 32'(10 + k));
    end
    step();
    check("s3_drained", bus.grf_we, 0);

    // writes to $0 from both sides
    bus.ra1 = 5'd0;
    drive_a(5'd0, $urandom, 32'h7000);
    drive_b(5'd0, $urandom, 32'h7004);
    step();
    idle_inputs();
    check("s4_a_zero", bus.grf_we, 0);
    check("s4_hit_zero", bus.hit1, 0);
    step();
    check("s4_b_zero", bus.grf_we, 0);
    check("s4_hold_wa", bus.grf_wa, 13);
    step();

    // reset discards buffered B writes
    drive_a(5'd3, 32'h3333, 32'h8000);
    for (int k = 0; k < 3; k++) begin
      drive_b(5'(21 + k), $urandom, 32'h9000);
      step();
    end
    idle_inputs();
    bus.ra1 = 5'd21; bus.ra2 = 5'd22;
    #1;
    check("s5_hit_before", bus.hit1, 1);
    reset = 1;
    step();
    check("s5_we", bus.grf_we, 0);
    check("s5_hit1", bus.hit1, 0);
    check("s5_hit2", bus.hit2, 0);
    check("s5_ready_in_reset", bus.md_ready, 0);
    reset = 0;
    #1;
    check("s5_ready_after", bus.md_ready, 1);
    step();
    check("s5_no_stale_write", bus.grf_we, 0);

    // randomized traffic against the model
    pct = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) pct = (c / 200) % 3 == 0 ? 90 : ((c / 200) % 3 == 1 ? 10 : 50);
      reset        = ($urandom_range(0, 299) == 0);
      bus.wb_we    = ($urandom_range(0, 99) < pct);
      bus.wb_wa    = 5'($urandom_range(0, 7));
      bus.wb_wd    = $urandom;
      bus.wb_pc    = $urandom;
      bus.md_valid = ($urandom_range(0, 99) < 60);
      bus.md_wa    = 5'($urandom_range(0, 7));
      bus.md_wd    = $urandom;
      bus.md_pc    = $urandom;
      bus.ra1      = 5'($urandom_range(0, 7));
      bus.ra2      = 5'($urandom_range(0, 7));
      step();
    end
    reset = 0;
    idle_inputs();
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
